// File: rtl/lfsr_rng_server_pkg.sv
// Shared definitions for the LFSR random-number server: tap mask, default seed and FSM states.
package lfsr_pkg;

    localparam logic [15:0] LFSR16_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR16_DEFAULT_SEED = 16'hbeef;

    typedef enum logic {
        FILL  = 1'b0,
        READY = 1'b1
    } rng_state_t;

    // Fibonacci feedback bit: XOR of the tapped bits (15, 13, 12, 10).
    function automatic logic lfsr16_feedback(input logic [15:0] s);
        return ^(s & LFSR16_TAPS);
    endfunction

endpackage

// File: rtl/lfsr_rng_server_rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first request at or after ptr, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx,
    output logic          valid
);

    // Scan offsets from farthest to nearest so the candidate closest to ptr wins.
    always_comb begin
        int k;
        grant     = '0;
        grant_idx = '0;
        valid     = |req;
        k         = 0;
        for (int i = N - 1; i >= 0; i--) begin
            k = (int'(ptr) + i) % N;
            if (req[k]) begin
                grant     = '0;
                grant[k]  = 1'b1;
                grant_idx = PW'(k);
            end
        end
    end

endmodule

// File: rtl/lfsr_rng_server.sv
// Shared 16-bit LFSR random-word server with round-robin req/ack delivery and software reseed.
// Optional macro LFSR_LOCKUP_GUARD_EN reloads SEED when the LFSR is found all-zero during FILL.
module lfsr_rng_server
    import lfsr_pkg::*;
#(
    parameter int          NREQ = 4,
    parameter int          W    = 6,
    parameter logic [15:0] SEED = LFSR16_DEFAULT_SEED
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] ack,
    output logic [W-1:0]    rnd_out,
    input  logic            seed_we,
    input  logic [15:0]     seed_in,
    output logic            busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    rng_state_t      state, state_n;
    logic [15:0]     lfsr, lfsr_n;
    logic [W-1:0]    acc, acc_n, acc_shifted;
    logic [CW-1:0]   cnt, cnt_n;
    logic [PW-1:0]   ptr, ptr_n;
    logic [NREQ-1:0] ack_n;
    logic [W-1:0]    rnd_n;
    logic            fb, lockup;
    logic [NREQ-1:0] pick_grant;
    logic [PW-1:0]   pick_idx;
    logic            pick_valid;

    assign fb   = lfsr16_feedback(lfsr);
    assign busy = (state == FILL);

`ifdef LFSR_LOCKUP_GUARD_EN
    assign lockup = (lfsr == 16'h0000);
`else
    assign lockup = 1'b0;
`endif

    // New bits enter at the LSB so the first bit of a word lands in the MSB.
    if (W == 1) begin : g_acc_single
        assign acc_shifted = fb;
    end else begin : g_acc_multi
        assign acc_shifted = {acc[W-2:0], fb};
    end

    rr_pick #(.N(NREQ), .PW(PW)) u_pick (
        .req       (req),
        .ptr       (ptr),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .valid     (pick_valid)
    );

    always_comb begin
        state_n = state;
        lfsr_n  = lfsr;
        acc_n   = acc;
        cnt_n   = cnt;
        ptr_n   = ptr;
        ack_n   = '0;
        rnd_n   = rnd_out;
        if (seed_we) begin
            lfsr_n  = seed_in;
            acc_n   = '0;
            cnt_n   = '0;
            state_n = FILL;
        end else begin
            unique case (state)
                FILL: begin
                    if (lockup) begin
                        lfsr_n = SEED;
                    end else begin
                        lfsr_n = {lfsr[14:0], fb};
                        acc_n  = acc_shifted;
                        if (cnt == CW'(W - 1)) begin
                            cnt_n   = '0;
                            state_n = READY;
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end
                end
                READY: begin
                    if (pick_valid) begin
                        ack_n   = pick_grant;
                        rnd_n   = acc;
                        ptr_n   = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
                        state_n = FILL;
                        cnt_n   = '0;
                    end
                end
                default: state_n = FILL;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FILL;
            lfsr    <= SEED;
            acc     <= '0;
            cnt     <= '0;
            ptr     <= '0;
            ack     <= '0;
            rnd_out <= '0;
        end else begin
            state   <= state_n;
            lfsr    <= lfsr_n;
            acc     <= acc_n;
            cnt     <= cnt_n;
            ptr     <= ptr_n;
            ack     <= ack_n;
            rnd_out <= rnd_n;
        end
    end

endmodule

// File: tb/tb_lfsr_rng_server.sv
// Scoreboard bench for lfsr_rng_server: directed phases push expected grants, a monitor checks them.
module tb_lfsr_rng_server;

    localparam int NREQ = 4;
    localparam int W    = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] ack;
    logic [W-1:0]    rnd_out;
    logic            seed_we;
    logic [15:0]     seed_in;
    logic            busy;

    typedef struct {
        logic [NREQ-1:0] ack;
        logic [W-1:0]    rnd;
        int              gap;
        string           name;
    } sb_entry_t;

    sb_entry_t sb[$];
    int tests_run      = 0;
    int tests_failed   = 0;
    int cycle          = 0;
    int last_ack_cycle = 0;

    lfsr_rng_server #(.NREQ(NREQ), .W(W), .SEED(16'hbeef)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .ack     (ack),
        .rnd_out (rnd_out),
        .seed_we (seed_we),
        .seed_in (seed_in),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] r, input logic we, input logic [15:0] sd);
        req     = r;
        seed_we = we;
        seed_in = sd;
    endtask

    task automatic pushExpected(input logic [NREQ-1:0] a, input logic [W-1:0] r, input int gap, input string name);
        sb_entry_t e;
        e.ack  = a;
        e.rnd  = r;
        e.gap  = gap;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Lets the monitor sample any pending ack, then pulses reset between edges.
    task automatic resetDut();
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    // Reference word generator straight from the feedback equation.
    task automatic modelWord(inout logic [15:0] s, output logic [W-1:0] w);
        logic f;
        w = '0;
        for (int i = 0; i < W; i++) begin
            f = s[15] ^ s[13] ^ s[12] ^ s[10];
            s = {s[14:0], f};
            w = {w[W-2:0], f};
        end
    endtask

    always @(negedge clk) begin
        sb_entry_t e;
        if (!rst && ack != '0) begin
            if (sb.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_ack: got ack=%b rnd=%0h, expected no grant", ack, rnd_out);
            end else begin
                e = sb.pop_front();
                checkOutput({e.name, "_ack"}, 32'(ack), 32'(e.ack));
                checkOutput({e.name, "_rnd"}, 32'(rnd_out), 32'(e.rnd));
                if (e.gap != 0)
                    checkOutput({e.name, "_gap"}, 32'(cycle - last_ack_cycle), 32'(e.gap));
            end
            last_ack_cycle = cycle;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0]     s;
        logic [W-1:0]    w;
        logic [NREQ-1:0] oh;

        rst = 1'b0;
        applyStimulus(4'b0100, 1'b0, 16'h0000);
        #1;
        rst = 1'b1;
        #2;
        checkOutput("reset_ack", 32'(ack), 32'h0);
        checkOutput("reset_rnd", 32'(rnd_out), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h1);
        rst = 1'b0;

        // Phase A: first word after reset goes to requester 2.
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("fill_busy_%0d", i), 32'(busy), 32'h1);
            tick(1);
        end
        checkOutput("ready_busy", 32'(busy), 32'h0);
        checkOutput("ready_lfsr", 32'(dut.lfsr), 32'hBBDB);
        pushExpected(4'b0100, 6'h1B, 0, "first_word");
        tick(1);
        applyStimulus(4'b0000, 1'b0, 16'h0000);
        checkOutput("post_grant_busy", 32'(busy), 32'h1);

        // Phase B: long idle in READY, then a single late request.
        resetDut();
        tick(26);
        checkOutput("idle_busy", 32'(busy), 32'h0);
        checkOutput("idle_lfsr", 32'(dut.lfsr), 32'hBBDB);
        checkOutput("idle_ack", 32'(ack), 32'h0);
        applyStimulus(4'b0010, 1'b0, 16'h0000);
        pushExpected(4'b0010, 6'h1B, 0, "late_req1");
        tick(1);
        applyStimulus(4'b0000, 1'b0, 16'h0000);

        // Phase C: all requesters held high, round-robin at one word per 7 cycles.
        resetDut();
        applyStimulus(4'b1111, 1'b0, 16'h0000);
        pushExpected(4'b0001, 6'h1B, 0, "rr0");
        s  = 16'hBBDB;
        oh = 4'b0001;
        for (int k = 1; k <= 4; k++) begin
            oh = {oh[NREQ-2:0], oh[NREQ-1]};
            modelWord(s, w);
            pushExpected(oh, w, 7, $sformatf("rr%0d", k));
        end
        tick(35);
        applyStimulus(4'b0000, 1'b0, 16'h0000);

        // Phase D: reseed collides with a pending grant and wins.
        resetDut();
        tick(6);
        applyStimulus(4'b0001, 1'b1, 16'hbeef);
        tick(1);
        applyStimulus(4'b0001, 1'b0, 16'h0000);
        checkOutput("reseed_busy", 32'(busy), 32'h1);
        checkOutput("reseed_ack", 32'(ack), 32'h0);
        checkOutput("reseed_lfsr", 32'(dut.lfsr), 32'hBEEF);
        pushExpected(4'b0001, 6'h1B, 0, "after_reseed");
        tick(7);
        applyStimulus(4'b0000, 1'b0, 16'h0000);

        // Phase E: zero reseed, with or without lockup recovery.
        applyStimulus(4'b0000, 1'b1, 16'h0000);
        tick(1);
        applyStimulus(4'b0001, 1'b0, 16'h0000);
`ifdef LFSR_LOCKUP_GUARD_EN
        s = 16'hBBDB;
        modelWord(s, w);
        pushExpected(4'b0001, 6'h1B, 0, "zero_seed_w0");
        pushExpected(4'b0001, w, 7, "zero_seed_w1");
        tick(15);
`else
        pushExpected(4'b0001, 6'h00, 0, "zero_seed_w0");
        pushExpected(4'b0001, 6'h00, 7, "zero_seed_w1");
        tick(14);
`endif
        applyStimulus(4'b0000, 1'b0, 16'h0000);

        // Phase F: asynchronous reset in the middle of a fill.
        resetDut();
        applyStimulus(4'b0001, 1'b0, 16'h0000);
        pushExpected(4'b0001, 6'h1B, 0, "pre_reset_word");
        tick(10);
        checkOutput("midfill_cnt", 32'(dut.cnt), 32'h3);
        checkOutput("midfill_rnd", 32'(rnd_out), 32'h1B);
        rst = 1'b1;
        #2;
        checkOutput("async_rst_rnd", 32'(rnd_out), 32'h0);
        checkOutput("async_rst_ack", 32'(ack), 32'h0);
        checkOutput("async_rst_busy", 32'(busy), 32'h1);
        checkOutput("async_rst_lfsr", 32'(dut.lfsr), 32'hBEEF);
        rst = 1'b0;
        pushExpected(4'b0001, 6'h1B, 0, "post_reset_word");
        tick(7);
        applyStimulus(4'b0000, 1'b0, 16'h0000);
        tick(3);

        checkOutput("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lfsr_rng_server.md
Name: lfsr_rng_server

Overview:
- Shares one 16-bit Fibonacci LFSR between NREQ requesters, each of which needs W-bit random words (replacement victim selection, arbitration jitter, and similar uses).
- Sequences the LFSR one bit per cycle into a W-bit accumulator. When the word is complete, grants it to one requester in round-robin order using a req/ack handshake.
- Supports software reseed.
- Sits beside the cache and scheduler blocks as the single shared random source.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 6, random word width (1..16).
- SEED, 16'hbeef, LFSR value loaded at reset.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req  in  NREQ  per-requester request level.
- ack  out  NREQ  one-hot grant pulse, registered.
- rnd_out  out  W  random word; valid in the cycle ack is high, held otherwise.
- seed_we  in  1  reseed strobe.
- seed_in  in  16  new LFSR value.
- busy  out  1  high while the accumulator is filling (state FILL).

Behaviour:
- Reset values (asynchronous): lfsr=SEED, acc=0, cnt=0, state=FILL, ptr=0, ack=0, rnd_out=0, busy=1.
- Feedback: f = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10].
- FILL state, each cycle:
  - lfsr <= {lfsr[14:0],f}; acc <= {acc[W-2:0],f}, so the first bit ends up in the MSB.
  - cnt increments. On the shift where cnt==W-1: cnt<=0, state<=READY.
  - A full word therefore takes exactly W cycles.
- READY state:
  - lfsr and acc hold.
  - With no request, the block waits in READY indefinitely.
  - If any req is high: winner g = first set bit at or after ptr, wrapping modulo NREQ.
  - On that edge: ack<=onehot(g), rnd_out<=acc, ptr<=(g+1) mod NREQ, state<=FILL, cnt<=0.
- ack is high for exactly one cycle, the first FILL cycle. All other cycles ack=0.
- Maximum throughput: one word per W+1 cycles.
- req is sampled only in READY.
  - A requester keeps req high until it sees ack.
  - It must drop req within W cycles of ack, or it becomes eligible again.
  - Dropping req before a grant is legal; no grant is issued to it.
- Every word is delivered exactly once. A word is never duplicated across requesters and never skipped while any req is pending.
- seed_we (any state) has priority over everything else:
  - lfsr<=seed_in, acc<=0, cnt<=0, state<=FILL.
  - No ack in the following cycle, even if a grant was due.
  - ptr is unchanged. rnd_out holds.
- Reset mid-fill or mid-grant: all state returns to its reset values immediately; any pending word is discarded.
- busy = (state==FILL).

Optional Feature:
- Macro: LFSR_LOCKUP_GUARD_EN.
- Defined: in any FILL cycle where lfsr==16'h0000, the block loads lfsr<=SEED instead of shifting; acc and cnt hold that cycle. This costs +1 cycle and exists to escape the all-zero lockup caused by a zero reseed.
- Undefined: no detection. A zero seed yields all-zero words forever; this is legal, deterministic behaviour.

Decomposition:
- Package lfsr_pkg holds:
  - LFSR16_TAPS (bits 15,13,12,10);
  - LFSR16_DEFAULT_SEED = 16'hbeef;
  - typedef enum logic {FILL, READY} rng_state_t.
- One sub-module: rr_pick (NREQ-wide round-robin one-hot picker taking req and ptr, returning grant and a valid flag). It is purely combinational and reusable by other arbiters.

Test Plan:
- Reset, then hold req=4'b0100:
  - busy=1 for 6 cycles;
  - ack=4'b0100 on the 7th edge after reset deasserts, with rnd_out=6'h1B;
  - internal lfsr=16'hBBDB.
- req=4'b1111 held constant: ack sequence 0001, 0010, 0100, 1000, 0001, with ack pulses exactly 7 cycles apart.
- req=0 for 20 cycles after fill: state stays READY, lfsr holds 16'hBBDB, and ack stays 0. Then raise req[1]: ack=4'b0010 on the next edge with rnd_out=6'h1B.
- seed_we with seed_in=16'hbeef asserted in the same READY cycle as req[0]: no ack; busy=1. After 6 cycles the next grant again carries 6'h1B.
- seed_we with seed_in=0:
  - with LFSR_LOCKUP_GUARD_EN defined, the next word equals 6'h1B (reload to SEED, delivered one cycle later);
  - with it undefined, every subsequent word is 6'h00.
- Assert rst while in FILL with cnt=3: all outputs reach their reset values asynchronously, before the next edge. After release, the first word is again 6'h1B.
